// File: rtl/rmap_pkg.sv
// Shared types and constants for the RMAP target authorisation controller:
// FSM states, command codes, status codes and command-class decode.
package rmap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RESP   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_REPORT = 3'd4
  } rmap_state_e;

  typedef enum logic [1:0] {
    CLS_INVALID = 2'd0,
    CLS_WRITE   = 2'd1,
    CLS_READ    = 2'd2,
    CLS_RMW     = 2'd3
  } rmap_cls_e;

  // Command field is {write, verify, reply, increment}
  localparam logic [3:0] CMD_RMW      = 4'b0111;
  localparam logic [3:0] CMD_READ     = 4'b0010;
  localparam logic [3:0] CMD_READ_INC = 4'b0011;

  localparam logic [7:0] ERR_NONE    = 8'd0;
  localparam logic [7:0] ERR_CMD     = 8'd2;
  localparam logic [7:0] ERR_KEY     = 8'd3;
  localparam logic [7:0] ERR_BUF     = 8'd10;
  localparam logic [7:0] ERR_RMW_LEN = 8'd11;
  localparam logic [7:0] ERR_LOGADDR = 8'd12;

  function automatic rmap_cls_e cmd_class(input logic [3:0] cmd);
    rmap_cls_e cls;
    if (cmd[3])
      cls = CLS_WRITE;
    else if (cmd == CMD_RMW)
      cls = CLS_RMW;
    else if (cmd == CMD_READ || cmd == CMD_READ_INC)
      cls = CLS_READ;
    else
      cls = CLS_INVALID;
    return cls;
  endfunction

endpackage

// File: rtl/rmap_auth_check.sv
// Combinational header check: first failing rule sets the status code and
// the matching invalid flag; the parent registers the result.
module rmap_auth_check
  import rmap_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [32:0] ADDR_SIZE = 33'h1_0000,
  parameter logic [23:0] MAX_LEN   = 24'd1024
) (
  input  logic [7:0]  log_addr_i,
  input  logic [7:0]  key_i,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] addr_i,
  input  logic [23:0] len_i,
  input  logic [7:0]  shadow_log_addr_i,
  input  logic [7:0]  shadow_key_i,
  output logic [7:0]  code_o,
  output logic        addr_inv_o,
  output logic        len_inv_o
);

  rmap_cls_e   cls;
  logic [33:0] end_addr;
  logic [33:0] win_end;
  logic        rmw_len_ok;

  // 34-bit sums so a window or access touching 4 GiB never wraps
  assign end_addr   = {2'b00, addr_i} + {10'd0, len_i};
  assign win_end    = {2'b00, ADDR_BASE} + {1'b0, ADDR_SIZE};
  assign cls        = cmd_class(cmd_i);
  assign rmw_len_ok = (len_i == 24'd0) || (len_i == 24'd2) || (len_i == 24'd4) ||
                      (len_i == 24'd6) || (len_i == 24'd8);

  always_comb begin
    code_o     = ERR_NONE;
    addr_inv_o = 1'b0;
    len_inv_o  = 1'b0;
    if (log_addr_i != shadow_log_addr_i) begin
      code_o = ERR_LOGADDR;
    end else if (key_i != shadow_key_i) begin
      code_o = ERR_KEY;
    end else if (cls == CLS_INVALID) begin
      code_o = ERR_CMD;
    end else if (cls == CLS_RMW && !rmw_len_ok) begin
      code_o    = ERR_RMW_LEN;
      len_inv_o = 1'b1;
    end else if (cls != CLS_RMW && len_i > MAX_LEN) begin
      code_o    = ERR_BUF;
      len_inv_o = 1'b1;
    end else if (addr_i < ADDR_BASE || end_addr > win_end) begin
      code_o     = ERR_BUF;
      addr_inv_o = 1'b1;
    end
  end

endmodule

// File: rtl/rmap_auth_ctrl.sv
// RMAP target authorisation/sequencing FSM. Optional saturating error
// counter is built when RMAP_AUTH_ERRCNT_EN is defined.
module rmap_auth_ctrl
  import rmap_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [32:0] ADDR_SIZE = 33'h1_0000,
  parameter logic [23:0] MAX_LEN   = 24'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  configKey,
  input  logic [7:0]  logicalAddress,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [7:0]  reqLogAddr,
  input  logic [7:0]  reqKey,
  input  logic [3:0]  reqCmd,
  input  logic [31:0] reqAddr,
  input  logic [23:0] reqLen,
  output logic        respValid,
  input  logic        respReady,
  output logic        respGrant,
  output logic [7:0]  respErrorCode,
  input  logic        opDone,
  input  logic        opError,
  input  logic [7:0]  opErrorCode,
  output logic [7:0]  rmapErrorCode,
  output logic        errorIndication,
  output logic        writeDataIndication,
  output logic        readDataIndication,
  output logic        rmwDataIndication,
  output logic        addrInvalid,
  output logic        dataLengthInvalid,
`ifdef RMAP_AUTH_ERRCNT_EN
  input  logic        errCountClr,
  output logic [15:0] errCount,
`endif
  output logic [2:0]  stateDbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.
  rmap_state_e state_q;
  logic        req_ready_q;
  logic [7:0]  la_q, key_q, sh_la_q, sh_key_q;
  logic [3:0]  cmd_q;
  logic [31:0] addr_q;
  logic [23:0] len_q;
  logic        resp_valid_q, resp_grant_q, ai_q, li_q;
  logic [7:0]  resp_code_q, err_code_q;
  logic        err_ind_q, wr_ind_q, rd_ind_q, rmw_ind_q, ai_ind_q, li_ind_q;

  logic [7:0]  chk_code;
  logic        chk_ai, chk_li;
  rmap_cls_e   cls;
  logic        rep_from_resp, rep_from_exec, rep_fire;
  logic [7:0]  rep_code;

  rmap_auth_check #(
    .ADDR_BASE(ADDR_BASE),
    .ADDR_SIZE(ADDR_SIZE),
    .MAX_LEN  (MAX_LEN)
  ) u_check (
    .log_addr_i       (la_q),
    .key_i            (key_q),
    .cmd_i            (cmd_q),
    .addr_i           (addr_q),
    .len_i            (len_q),
    .shadow_log_addr_i(sh_la_q),
    .shadow_key_i     (sh_key_q),
    .code_o           (chk_code),
    .addr_inv_o       (chk_ai),
    .len_inv_o        (chk_li)
  );

  assign cls           = cmd_class(cmd_q);
  assign rep_from_resp = (state_q == ST_RESP) && respReady && !resp_grant_q;
  assign rep_from_exec = (state_q == ST_EXEC) && opDone;
  assign rep_fire      = rep_from_resp || rep_from_exec;
  assign rep_code      = rep_from_exec ? (opError ? opErrorCode : ERR_NONE) : resp_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      la_q         <= '0;
      key_q        <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      sh_la_q      <= '0;
      sh_key_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_grant_q <= 1'b0;
      resp_code_q  <= '0;
      ai_q         <= 1'b0;
      li_q         <= 1'b0;
      err_code_q   <= '0;
      err_ind_q    <= 1'b0;
      wr_ind_q     <= 1'b0;
      rd_ind_q     <= 1'b0;
      rmw_ind_q    <= 1'b0;
      ai_ind_q     <= 1'b0;
      li_ind_q     <= 1'b0;
    end else begin
      err_ind_q <= 1'b0;
      wr_ind_q  <= 1'b0;
      rd_ind_q  <= 1'b0;
      rmw_ind_q <= 1'b0;
      ai_ind_q  <= 1'b0;
      li_ind_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_ready_q && reqValid) begin
            la_q        <= reqLogAddr;
            key_q       <= reqKey;
            cmd_q       <= reqCmd;
            addr_q      <= reqAddr;
            len_q       <= reqLen;
            sh_la_q     <= logicalAddress;
            sh_key_q    <= configKey;
            req_ready_q <= 1'b0;
            state_q     <= ST_CHECK;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_CHECK: begin
          resp_valid_q <= 1'b1;
          resp_grant_q <= (chk_code == ERR_NONE);
          resp_code_q  <= chk_code;
          ai_q         <= chk_ai;
          li_q         <= chk_li;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (respReady) begin
            resp_valid_q <= 1'b0;
            state_q      <= resp_grant_q ? ST_EXEC : ST_REPORT;
          end
        end
        ST_EXEC: begin
          if (opDone) state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (rep_fire) begin
        err_code_q <= rep_code;
        err_ind_q  <= (rep_code != ERR_NONE);
        wr_ind_q   <= (rep_code == ERR_NONE) && (cls == CLS_WRITE);
        rd_ind_q   <= (rep_code == ERR_NONE) && (cls == CLS_READ);
        rmw_ind_q  <= (rep_code == ERR_NONE) && (cls == CLS_RMW);
        ai_ind_q   <= rep_from_resp && ai_q;
        li_ind_q   <= rep_from_resp && li_q;
      end
    end
  end

`ifdef RMAP_AUTH_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || errCountClr)
      err_cnt_q <= '0;
    else if (state_q == ST_REPORT && err_code_q != ERR_NONE && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign errCount = err_cnt_q;
`endif

  assign reqReady            = req_ready_q;
  assign respValid           = resp_valid_q;
  assign respGrant           = resp_grant_q;
  assign respErrorCode       = resp_code_q;
  assign rmapErrorCode       = err_code_q;
  assign errorIndication     = err_ind_q;
  assign writeDataIndication = wr_ind_q;
  assign readDataIndication  = rd_ind_q;
  assign rmwDataIndication   = rmw_ind_q;
  assign addrInvalid         = ai_ind_q;
  assign dataLengthInvalid   = li_ind_q;
  assign stateDbg            = state_q;

endmodule

// File: tb/tb_rmap_auth_ctrl.sv
// Directed bench for rmap_auth_ctrl: expected decisions and reports are queued
// by the driver and popped by an independent monitor on each DUT output.
module tb_rmap_auth_ctrl;
  import rmap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  configKey = 8'h20, logicalAddress = 8'hFE;
  logic        reqValid = 1'b0, reqReady;
  logic [7:0]  reqLogAddr = '0, reqKey = '0;
  logic [3:0]  reqCmd = '0;
  logic [31:0] reqAddr = '0;
  logic [23:0] reqLen = '0;
  logic        respValid, respReady = 1'b0, respGrant;
  logic [7:0]  respErrorCode;
  logic        opDone = 1'b0, opError = 1'b0;
  logic [7:0]  opErrorCode = '0;
  logic [7:0]  rmapErrorCode;
  logic        errorIndication, writeDataIndication, readDataIndication;
  logic        rmwDataIndication, addrInvalid, dataLengthInvalid;
  logic        errCountClr = 1'b0;
  logic [15:0] errCount;
  logic [2:0]  stateDbg;

  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_resp_q[$];
  logic [13:0] exp_q[$];
  logic [8:0]  mon_resp;
  logic [13:0] mon_rep;

  always #5 clk = ~clk;

  rmap_auth_ctrl dut (
    .clk(clk), .rst(rst), .configKey(configKey), .logicalAddress(logicalAddress),
    .reqValid(reqValid), .reqReady(reqReady), .reqLogAddr(reqLogAddr), .reqKey(reqKey),
    .reqCmd(reqCmd), .reqAddr(reqAddr), .reqLen(reqLen),
    .respValid(respValid), .respReady(respReady), .respGrant(respGrant),
    .respErrorCode(respErrorCode), .opDone(opDone), .opError(opError),
    .opErrorCode(opErrorCode), .rmapErrorCode(rmapErrorCode),
    .errorIndication(errorIndication), .writeDataIndication(writeDataIndication),
    .readDataIndication(readDataIndication), .rmwDataIndication(rmwDataIndication),
    .addrInvalid(addrInvalid), .dataLengthInvalid(dataLengthInvalid),
`ifdef RMAP_AUTH_ERRCNT_EN
    .errCountClr(errCountClr), .errCount(errCount),
`endif
    .stateDbg(stateDbg)
  );

`ifndef RMAP_AUTH_ERRCNT_EN
  assign errCount = 16'h0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk_rep(input logic e, input logic w, input logic r,
                                         input logic m, input logic a, input logic l,
                                         input logic [7:0] c);
    return {e, w, r, m, a, l, c};
  endfunction

  // Monitor: pops one expectation per accepted decision and per report pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (respValid && respReady) begin
        if (exp_resp_q.size() == 0) begin
          check("resp_unexpected", {23'd0, respGrant, respErrorCode}, 32'hFFFF_FFFF);
        end else begin
          mon_resp = exp_resp_q.pop_front();
          check("resp_fields", {23'd0, respGrant, respErrorCode}, {23'd0, mon_resp});
        end
      end
      if (errorIndication | writeDataIndication | readDataIndication |
          rmwDataIndication | addrInvalid | dataLengthInvalid) begin
        if (exp_q.size() == 0) begin
          check("report_unexpected", {18'd0, errorIndication, writeDataIndication,
                readDataIndication, rmwDataIndication, addrInvalid, dataLengthInvalid,
                rmapErrorCode}, 32'hFFFF_FFFF);
        end else begin
          mon_rep = exp_q.pop_front();
          check("report_fields", {18'd0, errorIndication, writeDataIndication,
                readDataIndication, rmwDataIndication, addrInvalid, dataLengthInvalid,
                rmapErrorCode}, {18'd0, mon_rep});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!reqReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!reqReady) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_hdr(input logic [7:0] la, input logic [7:0] key, input logic [3:0] cmd,
                          input logic [31:0] addr, input logic [23:0] len);
    wait_ready();
    reqLogAddr = la; reqKey = key; reqCmd = cmd; reqAddr = addr; reqLen = len;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] la, input logic [7:0] key, input logic [3:0] cmd,
                         input logic [31:0] addr, input logic [23:0] len,
                         input logic exp_grant, input logic [7:0] exp_code,
                         input logic [13:0] exp_rep, input logic op_err,
                         input logic [7:0] op_code, input int hold, input logic clr);
    logic [7:0] sv_key, sv_la;
    sv_key = configKey; sv_la = logicalAddress;
    exp_resp_q.push_back({exp_grant, exp_code});
    exp_q.push_back(exp_rep);
    send_hdr(la, key, cmd, addr, len);
    if (hold == 0) respReady = 1'b1;
    else begin
      configKey = 8'h5A; logicalAddress = 8'h00;
    end
    check("resp_valid_n1", {31'd0, respValid}, 32'd0);
    @(posedge clk); #1;
    check("resp_valid_n2", {31'd0, respValid}, 32'd1);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("resp_hold", {22'd0, respValid, respGrant, respErrorCode},
              {22'd0, 1'b1, exp_grant, exp_code});
      end
      respReady = 1'b1;
    end
    @(posedge clk); #1;
    respReady = 1'b0;
    if (!exp_grant) begin
      check("reject_pulse", {31'd0, errorIndication}, 32'd1);
      if (clr) errCountClr = 1'b1;
    end else begin
      repeat (2) @(posedge clk);
      #1;
      check("exec_state", {29'd0, stateDbg}, {29'd0, ST_EXEC});
      opDone = 1'b1; opError = op_err; opErrorCode = op_code;
      @(posedge clk); #1;
      opDone = 1'b0; opError = 1'b0; opErrorCode = '0;
      check("done_pulse", {31'd0, errorIndication | writeDataIndication |
            readDataIndication | rmwDataIndication}, 32'd1);
    end
    @(posedge clk); #1;
    errCountClr = 1'b0;
    check("req_ready_back", {31'd0, reqReady}, 32'd1);
    check("err_code_hold", {24'd0, rmapErrorCode}, {24'd0, exp_rep[7:0]});
    configKey = sv_key; logicalAddress = sv_la;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {24'd0, reqReady, respValid, respGrant, errorIndication,
          writeDataIndication, readDataIndication, rmwDataIndication, addrInvalid},
          32'd0);
    check("rst_err_code", {24'd0, rmapErrorCode}, 32'd0);
    check("rst_errcount", {16'd0, errCount}, 32'd0);
    rst = 1'b0;
    check("ready_low_after_rst", {31'd0, reqReady}, 32'd0);
    @(posedge clk); #1;
    check("ready_high_after_rst", {31'd0, reqReady}, 32'd1);

    // Grants and rejects across command classes and boundaries
    run_cmd(8'hFE, 8'h20, 4'b1100, 32'h100, 24'd16, 1'b1, 8'd0,
            mk_rep(0, 1, 0, 0, 0, 0, 8'd0), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFD, 8'h21, 4'b1100, 32'h100, 24'd16, 1'b0, 8'd12,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd12), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h21, 4'b1100, 32'h100, 24'd16, 1'b0, 8'd3,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd3), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0100, 32'h100, 24'd16, 1'b0, 8'd2,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd2), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0001, 32'h100, 24'd16, 1'b0, 8'd2,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd2), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0111, 32'h100, 24'd3, 1'b0, 8'd11,
            mk_rep(1, 0, 0, 0, 0, 1, 8'd11), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0111, 32'h100, 24'd4, 1'b1, 8'd0,
            mk_rep(0, 0, 0, 1, 0, 0, 8'd0), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0010, 32'hFFF8, 24'd16, 1'b0, 8'd10,
            mk_rep(1, 0, 0, 0, 1, 0, 8'd10), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0010, 32'hFFF0, 24'd16, 1'b1, 8'd0,
            mk_rep(0, 0, 1, 0, 0, 0, 8'd0), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b1000, 32'h0, 24'd1025, 1'b0, 8'd10,
            mk_rep(1, 0, 0, 0, 0, 1, 8'd10), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b1000, 32'h0, 24'd1024, 1'b1, 8'd0,
            mk_rep(0, 1, 0, 0, 0, 0, 8'd0), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b1011, 32'hFFFF_FFF0, 24'h20, 1'b0, 8'd10,
            mk_rep(1, 0, 0, 0, 1, 0, 8'd10), 1'b0, 8'd0, 0, 1'b0);
    run_cmd(8'hFE, 8'h20, 4'b0011, 32'h200, 24'd8, 1'b1, 8'd0,
            mk_rep(1, 0, 0, 0, 0, 0, 8'h09), 1'b1, 8'h09, 0, 1'b0);
    // Config changed after header capture, decision held off for 5 cycles
    run_cmd(8'hFE, 8'h20, 4'b1100, 32'h100, 24'd16, 1'b1, 8'd0,
            mk_rep(0, 1, 0, 0, 0, 0, 8'd0), 1'b0, 8'd0, 5, 1'b0);

    // opDone while idle must produce nothing (monitor flags any pulse)
    opDone = 1'b1;
    @(posedge clk); #1;
    opDone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_opdone_ignored", {29'd0, stateDbg}, {29'd0, ST_IDLE});

    // Leave a non-zero code, then reset in the middle of an execution
    run_cmd(8'hFE, 8'h21, 4'b1100, 32'h100, 24'd16, 1'b0, 8'd3,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd3), 1'b0, 8'd0, 0, 1'b0);
    exp_resp_q.push_back({1'b1, 8'd0});
    send_hdr(8'hFE, 8'h20, 4'b1100, 32'h100, 24'd16);
    respReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    respReady = 1'b0;
    check("exec_before_rst", {29'd0, stateDbg}, {29'd0, ST_EXEC});
    rst = 1'b1;
    opDone = 1'b1;
    @(posedge clk); #1;
    opDone = 1'b0;
    check("rst_exec_outputs", {24'd0, reqReady, respValid, errorIndication,
          writeDataIndication, readDataIndication, rmwDataIndication, addrInvalid,
          dataLengthInvalid}, 32'd0);
    check("rst_exec_code", {24'd0, rmapErrorCode}, 32'd0);
    check("rst_exec_state", {29'd0, stateDbg}, {29'd0, ST_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", {31'd0, reqReady}, 32'd1);
    run_cmd(8'hFE, 8'h20, 4'b0010, 32'h0, 24'd4, 1'b1, 8'd0,
            mk_rep(0, 0, 1, 0, 0, 0, 8'd0), 1'b0, 8'd0, 0, 1'b0);

`ifdef RMAP_AUTH_ERRCNT_EN
    errCountClr = 1'b1;
    @(posedge clk); #1;
    errCountClr = 1'b0;
    check("errcnt_cleared", {16'd0, errCount}, 32'd0);
    repeat (3)
      run_cmd(8'hFE, 8'h21, 4'b1100, 32'h100, 24'd16, 1'b0, 8'd3,
              mk_rep(1, 0, 0, 0, 0, 0, 8'd3), 1'b0, 8'd0, 0, 1'b0);
    check("errcnt_three", {16'd0, errCount}, 32'd3);
    run_cmd(8'hFE, 8'h21, 4'b1100, 32'h100, 24'd16, 1'b0, 8'd3,
            mk_rep(1, 0, 0, 0, 0, 0, 8'd3), 1'b0, 8'd0, 0, 1'b1);
    check("errcnt_clr_wins", {16'd0, errCount}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_empty", exp_resp_q.size(), 32'd0);
    check("report_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
